// File: rtl/contador_vagas_param_if.sv
// ----------------------------------------------------------------------------
// contador_vagas_param_if
// Bundle between the parking-spot sensors and the display/gate logic.
// The master drives the sensor side and reads the counts; the slave
// (contador_vagas_param) does the counting.
//
// Optional macro: VAGAS_RESERVA_EN adds reserva_i (reserved-spot mask).
//
// Signals:
//   vagas_i     [N_VAGAS] raw sensor bits, 1 = spot occupied (async to clk)
//   reserva_i   [N_VAGAS] reserved-spot mask, sync to clk (VAGAS_RESERVA_EN)
//   ocupadas_o  [W]       registered occupied-spot count
//   livres_o    [W]       registered free-spot count
//   lotado_o              lot full
//   vazio_o               lot empty
//   alteracao_o           one-cycle pulse on count change
//   estado_o    [N_VAGAS] debounced per-spot occupancy
// ----------------------------------------------------------------------------
interface contador_vagas_param_if #(
    parameter int N_VAGAS = 8
);
    localparam int W = $clog2(N_VAGAS + 1);

    logic [N_VAGAS-1:0] vagas_i;
`ifdef VAGAS_RESERVA_EN
    logic [N_VAGAS-1:0] reserva_i;
`endif
    logic [W-1:0]       ocupadas_o;
    logic [W-1:0]       livres_o;
    logic               lotado_o;
    logic               vazio_o;
    logic               alteracao_o;
    logic [N_VAGAS-1:0] estado_o;

`ifdef VAGAS_RESERVA_EN
    modport master (
        output vagas_i, reserva_i,
        input  ocupadas_o, livres_o, lotado_o, vazio_o, alteracao_o, estado_o
    );
    modport slave (
        input  vagas_i, reserva_i,
        output ocupadas_o, livres_o, lotado_o, vazio_o, alteracao_o, estado_o
    );
`else
    modport master (
        output vagas_i,
        input  ocupadas_o, livres_o, lotado_o, vazio_o, alteracao_o, estado_o
    );
    modport slave (
        input  vagas_i,
        output ocupadas_o, livres_o, lotado_o, vazio_o, alteracao_o, estado_o
    );
`endif
endinterface

// File: rtl/contador_vagas_param.sv
// ----------------------------------------------------------------------------
// contador_vagas_param
// Clocked parking-spot counter. Each raw sensor is synchronised (2 flops),
// debounced by a per-channel two-state FSM, and the debounced occupancy is
// popcounted into registered occupied/free counts with full/empty flags and
// a one-cycle change strobe.
//
// Optional macro: VAGAS_RESERVA_EN -- when defined, bus.reserva_i marks
// reserved spots that count as occupied (no debounce, one-cycle latency);
// estado_o still shows only the debounced sensors.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    contador_vagas_param_if.slave (sensors in, counts/flags out)
// ----------------------------------------------------------------------------
module contador_vagas_param #(
    parameter int N_VAGAS      = 8,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    contador_vagas_param_if.slave        bus
);
    localparam int              W       = $clog2(N_VAGAS + 1);
    localparam logic [7:0]      CNT_MAX = 8'(DEBOUNCE_CYC - 1);
    localparam logic [W-1:0]    N_W     = W'(N_VAGAS);

    typedef enum logic {
        ESTAVEL  = 1'b0,
        CONTANDO = 1'b1
    } t_deb;

    logic [N_VAGAS-1:0] r_sync1;
    logic [N_VAGAS-1:0] r_sync2;
    logic [N_VAGAS-1:0] r_estado;
    t_deb               r_fsm [N_VAGAS];
    logic [7:0]         r_cnt [N_VAGAS];

    logic [W-1:0]       r_ocup;
    logic [W-1:0]       r_livres;
    logic               r_lotado;
    logic               r_vazio;
    logic               r_alt;

    logic [N_VAGAS-1:0] w_efetivo;
    logic [W-1:0]       w_ocup_next;

    function automatic logic [W-1:0] f_popcount(input logic [N_VAGAS-1:0] v);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < N_VAGAS; i++) begin
            s = s + W'(v[i]);
        end
        return s;
    endfunction

    // Synchroniser and per-channel debounce. The FSM spends one cycle in
    // ESTAVEL noticing the mismatch before counting, so a change seen on
    // sync commits DEBOUNCE_CYC+1 cycles later; any return to the current
    // state throws the partial count away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_estado <= '0;
            for (int i = 0; i < N_VAGAS; i++) begin
                r_fsm[i] <= ESTAVEL;
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= bus.vagas_i;
            r_sync2 <= r_sync1;
            for (int i = 0; i < N_VAGAS; i++) begin
                case (r_fsm[i])
                    ESTAVEL: begin
                        r_cnt[i] <= '0;
                        if (r_sync2[i] != r_estado[i]) begin
                            r_fsm[i] <= CONTANDO;
                        end
                    end
                    CONTANDO: begin
                        if (r_sync2[i] == r_estado[i]) begin
                            r_fsm[i] <= ESTAVEL;
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == CNT_MAX) begin
                            r_estado[i] <= r_sync2[i];
                            r_fsm[i]    <= ESTAVEL;
                            r_cnt[i]    <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 8'd1;
                        end
                    end
                    default: begin
                        r_fsm[i] <= ESTAVEL;
                        r_cnt[i] <= '0;
                    end
                endcase
            end
        end
    end

`ifdef VAGAS_RESERVA_EN
    assign w_efetivo = r_estado | bus.reserva_i;
`else
    assign w_efetivo = r_estado;
`endif

    assign w_ocup_next = f_popcount(w_efetivo);

    // Counts and flags all come from the same next value, so occupied/free
    // and the flags are always mutually consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ocup   <= '0;
            r_livres <= N_W;
            r_lotado <= 1'b0;
            r_vazio  <= 1'b1;
            r_alt    <= 1'b0;
        end else begin
            r_ocup   <= w_ocup_next;
            r_livres <= N_W - w_ocup_next;
            r_lotado <= (w_ocup_next == N_W);
            r_vazio  <= (w_ocup_next == '0);
            r_alt    <= (w_ocup_next != r_ocup);
        end
    end

    assign bus.ocupadas_o  = r_ocup;
    assign bus.livres_o    = r_livres;
    assign bus.lotado_o    = r_lotado;
    assign bus.vazio_o     = r_vazio;
    assign bus.alteracao_o = r_alt;
    assign bus.estado_o    = r_estado;

endmodule
